// File: rtl/fp_norm_round.sv
// fp_norm_round: normalize, round-to-nearest-even and pack the 48-bit mantissa
// product of the single-precision multiplier into an IEEE-754 single result.
// Fixed four-state sequence IDLE -> NORM -> ROUND -> PACK with a one-cycle done.
module fp_norm_round #(
  parameter int          EXP_W       = 10,
  parameter logic [31:0] NAN_PATTERN = 32'h7FC0_0000
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  input  logic [47:0]             prod,
  input  logic                    sign_in,
  input  logic signed [EXP_W-1:0] exp_sum,
  input  logic                    nan_in,
  input  logic                    inf_in,
  input  logic                    zero_in,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             result,
  output logic                    overflow,
  output logic                    underflow
);

  localparam logic signed [EXP_W-1:0] EXP_ONE = EXP_W'(1);
  localparam logic signed [EXP_W-1:0] EXP_MAX = EXP_W'(255);
  localparam logic signed [EXP_W-1:0] EXP_MIN = EXP_W'(0);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, PACK} state_t;

  state_t state, state_nxt;

  // capture stage
  logic [47:0]             prod_p0;
  logic                    sign_p0;
  logic signed [EXP_W-1:0] exp_p0;
  logic                    nan_p0;
  logic                    inf_p0;
  logic                    zero_p0;

  // normalize stage
  logic [23:0]             mant_p1;
  logic                    guard_p1;
  logic                    sticky_p1;
  logic signed [EXP_W-1:0] exp_p1;
  logic                    zero_p1;

  // round/pack (combinational into the output registers)
  logic [24:0]             rnd_sum_p2;
  logic signed [EXP_W-1:0] exp_p2;
  logic                    zero_p2;
  logic [33:0]             packed_p2;

  // Round-to-nearest-even on a 24-bit mantissa; bit 24 of the sum is the carry-out.
  function automatic logic [24:0] round_rne(input logic [23:0] mant,
                                            input logic        guard,
                                            input logic        sticky);
    logic round_up;
    round_up  = guard & (sticky | mant[0]);
    round_rne = {1'b0, mant} + {24'd0, round_up};
  endfunction

  // Special-case priority, exponent saturation and packing; returns {ovf, unf, word}.
  function automatic logic [33:0] pack_result(input logic                    sign,
                                              input logic                    nan,
                                              input logic                    inf,
                                              input logic                    zero,
                                              input logic signed [EXP_W-1:0] exp,
                                              input logic [22:0]             frac);
    if (nan)
      pack_result = {2'b00, NAN_PATTERN};
    else if (inf)
      pack_result = {2'b00, sign, 8'hFF, 23'h0};
    else if (zero)
      pack_result = {2'b00, sign, 31'h0};
    else if (exp >= EXP_MAX)
      pack_result = {2'b10, sign, 8'hFF, 23'h0};
    else if (exp <= EXP_MIN)
      pack_result = {2'b01, sign, 31'h0};
    else
      pack_result = {2'b00, sign, exp[7:0], frac};
  endfunction

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic: only IDLE waits on in_valid, the rest is a fixed walk.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = NORM;
      NORM:    state_nxt = ROUND;
      ROUND:   state_nxt = PACK;
      PACK:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture operands once per pass through IDLE; ignored while busy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prod_p0 <= '0;
      sign_p0 <= 1'b0;
      exp_p0  <= '0;
      nan_p0  <= 1'b0;
      inf_p0  <= 1'b0;
      zero_p0 <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      prod_p0 <= prod;
      sign_p0 <= sign_in;
      exp_p0  <= exp_sum;
      nan_p0  <= nan_in;
      inf_p0  <= inf_in;
      zero_p0 <= zero_in;
    end
  end

  // Normalize: a product in [2,4) shifts one more place and bumps the exponent.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mant_p1   <= '0;
      guard_p1  <= 1'b0;
      sticky_p1 <= 1'b0;
      exp_p1    <= '0;
      zero_p1   <= 1'b0;
    end else if (state == NORM) begin
      if (prod_p0[47]) begin
        mant_p1   <= prod_p0[47:24];
        guard_p1  <= prod_p0[23];
        sticky_p1 <= |prod_p0[22:0];
        exp_p1    <= exp_p0 + EXP_ONE;
      end else begin
        mant_p1   <= prod_p0[46:23];
        guard_p1  <= prod_p0[22];
        sticky_p1 <= |prod_p0[21:0];
        exp_p1    <= exp_p0;
      end
      // A product below 1.0 with no special flag can only come from a zero operand.
      zero_p1 <= zero_p0 | ((prod_p0[47:46] == 2'b00) & ~nan_p0 & ~inf_p0);
    end
  end

  // Round and pack. On carry-out the low 24 bits of the sum are already zero,
  // which is exactly the fraction of 1.0 at the incremented exponent.
  always_comb begin
    rnd_sum_p2 = round_rne(mant_p1, guard_p1, sticky_p1);
    exp_p2     = rnd_sum_p2[24] ? (exp_p1 + EXP_ONE) : exp_p1;
    // Missing hidden bit after rounding also means the value is below 1.0.
    zero_p2    = zero_p1 | ~(rnd_sum_p2[24] | rnd_sum_p2[23]);
    packed_p2  = pack_result(sign_p0, nan_p0, inf_p0, zero_p2, exp_p2, rnd_sum_p2[22:0]);
  end

  // Output registers: flags clear on capture, result/flags load when entering PACK.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      done <= (state == ROUND);
      case (state)
        IDLE: if (in_valid) begin
          busy      <= 1'b1;
          overflow  <= 1'b0;
          underflow <= 1'b0;
        end
        ROUND: begin
          overflow  <= packed_p2[33];
          underflow <= packed_p2[32];
          result    <= packed_p2[31:0];
        end
        PACK: busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
